mc_control_unit: RTL and testbench

Multicycle MIPS control FSM, next generation of the datapath controller. It adds a variable-latency memory handshake, an extended instruction set (BNE, ANDI, ORI, SLTI, JAL) and an illegal-opcode trap. Optional retire/stall counters support performance work. It sits between the instruction register opcode field and the multicycle datapath muxes and enables.

---
 rtl/mc_control_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM. It drives the datapath muxes and enables
// from the IR opcode and waits on a variable-latency memory handshake
// (mem_ready). Illegal opcodes go to a trap state that pulses `illegal`.
//
// Build option:
//   MC_CTRL_PERF_EN  adds the instr_retired / stall_cycles counters.
//                    When it is undefined, both ports are tied to zero.
//
// State table:
//   state  | meaning
//   FETCH  | fetch the instruction at PC; PC += 4 and IR load on mem_ready
//   DECODE | read registers; ALUOut = PC + (imm << 2) as branch target
//   MEMADR | ALUOut = A + sign-ext imm (lw/sw address)
//   MEMRD  | load access, waits for mem_ready
//   MEMWB  | write load data to rt
//   MEMWR  | store access, strobe held until mem_ready
//   RTEX   | R-type ALU operation
//   RTWB   | write ALU result to rd
//   BRANCH | compare A and B; conditional PC write (beq/bne)
//   IMMEX  | immediate ALU operation (addi/andi/ori/slti)
//   IMMWB  | write ALU result to rt
//   JUMP   | PC = jump target
//   JAL    | PC = jump target, $31 = PC
//   TRAP   | PC = exception vector, pulse illegal
module mc_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             pc_write,
    output logic             branch,
    output logic             branch_ne,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_retired,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    state_t state_q, state_d;

    // Next-state selection; the opcode is read straight from the IR, which
    // stays stable for the whole instruction after FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE:                         state_d = S_RTEX;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
                    OP_J:                             state_d = S_JUMP;
                    OP_JAL:                           state_d = S_JAL;
                    default:                          state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTEX:   state_d = S_RTWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB, S_RTWB, S_BRANCH, S_IMMWB,
            S_JUMP, S_JAL, S_TRAP:
                      state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register; reset forces FETCH asynchronously, aborting any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Datapath controls decoded from the current state. In FETCH, the IR load
    // and PC write follow mem_ready so they fire only in the completing cycle.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                branch    = (opcode == OP_BEQ);
                branch_ne = (opcode == OP_BNE);
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_IMMWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            S_JAL: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
            end
            S_TRAP: begin
                pc_src   = 2'b11;
                pc_write = 1'b1;
                illegal  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] instr_retired_q, stall_cycles_q;

    // Retire on every entry into FETCH (traps included); count memory wait cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_retired_q <= '0;
            stall_cycles_q  <= '0;
        end else begin
            if (state_q != S_FETCH && state_d == S_FETCH)
                instr_retired_q <= instr_retired_q + 1'b1;
            if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !mem_ready)
                stall_cycles_q <= stall_cycles_q + 1'b1;
        end
    end

    assign instr_retired = instr_retired_q;
    assign stall_cycles  = stall_cycles_q;
`else
    assign instr_retired = '0;
    assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed instruction table plus random
// instruction stream, checked against a phase-sequence reference model.
module tb_mc_control_unit;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             mem_req, iord, mem_write, ir_write, reg_write;
    logic [1:0]       reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic             alu_src_a, pc_write, branch, branch_ne, illegal;
    logic [2:0]       alu_op;
    logic [CNT_W-1:0] instr_retired, stall_cycles;

    mc_control_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne),
        .illegal(illegal), .instr_retired(instr_retired), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, iord, mem_write, ir_write, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write, branch, branch_ne, illegal;
    } out_t;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_RTEX, P_RTWB,
                  P_BRANCH, P_IMMEX, P_IMMWB, P_JUMP, P_JAL, P_TRAP} phase_t;
    typedef enum {C_LW, C_SW, C_R, C_BR, C_IMM, C_J, C_JAL, C_ILL} cls_t;
    typedef struct {
        logic [5:0] op;
        int         wf;
        int         wm;
        int         cycles;
    } vec_t;

    out_t dut_o;
    assign dut_o = {mem_req, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                    alu_src_a, alu_src_b, alu_op, pc_src, pc_write, branch, branch_ne, illegal};

    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_W-1:0] ret_m = '0;
    logic [CNT_W-1:0] stall_m = '0;
    int cyc = 0, last_entry = 0, pending = 0, next_exp = 0;
    bit prev_in_fetch = 1'b0;

    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_R;
            6'b000100, 6'b000101: return C_BR;
            6'b001000, 6'b001100, 6'b001101, 6'b001010: return C_IMM;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic out_t exp_out(input phase_t ph, input logic [5:0] op, input logic rdy);
        out_t e;
        e = '0;
        case (ph)
            P_FETCH:  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            P_DECODE: e.alu_src_b = 2'b11;
            P_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            P_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
            P_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; end
            P_MEMWR:  begin e.mem_req = 1; e.iord = 1; e.mem_write = 1; end
            P_RTEX:   begin e.alu_src_a = 1; e.alu_op = 3'b010; end
            P_RTWB:   begin e.reg_write = 1; e.reg_dst = 2'b01; end
            P_BRANCH: begin
                e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_src = 2'b01;
                e.branch = (op == 6'b000100); e.branch_ne = (op == 6'b000101);
            end
            P_IMMEX:  begin
                e.alu_src_a = 1; e.alu_src_b = 2'b10;
                e.alu_op = (op == 6'b001100) ? 3'b011 :
                           (op == 6'b001101) ? 3'b100 :
                           (op == 6'b001010) ? 3'b101 : 3'b000;
            end
            P_IMMWB:  e.reg_write = 1;
            P_JUMP:   begin e.pc_src = 2'b10; e.pc_write = 1; end
            P_JAL:    begin
                e.pc_src = 2'b10; e.pc_write = 1; e.reg_write = 1;
                e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
            end
            P_TRAP:   begin e.pc_src = 2'b11; e.pc_write = 1; e.illegal = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_counters(input string tag);
        logic [CNT_W-1:0] er, es;
`ifdef MC_CTRL_PERF_EN
        er = ret_m;
        es = stall_m;
`else
        er = '0;
        es = '0;
`endif
        n_tests++;
        if (instr_retired !== er) begin
            n_fail++;
            $display("FAIL %s instr_retired got=%0d exp=%0d", tag, instr_retired, er);
        end
        n_tests++;
        if (stall_cycles !== es) begin
            n_fail++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", tag, stall_cycles, es);
        end
    endtask

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic cycle(input phase_t ph, input logic [5:0] op, input logic rdy, input logic last);
        out_t e;
        bit in_fetch;
        opcode = op;
        mem_ready = rdy;
        #1;
        e = exp_out(ph, op, rdy);
        n_tests++;
        if (dut_o !== e) begin
            n_fail++;
            $display("FAIL outputs ph=%s op=%b rdy=%0d got=%h exp=%h", ph.name(), op, rdy, dut_o, e);
        end
        check_counters(ph.name());
        in_fetch = mem_req && !iord;
        if (in_fetch && !prev_in_fetch) begin
            if (pending != 0) begin
                n_tests++;
                if (cyc - last_entry != pending) begin
                    n_fail++;
                    $display("FAIL instr_len got=%0d exp=%0d", cyc - last_entry, pending);
                end
            end
            last_entry = cyc;
            pending = next_exp;
        end
        prev_in_fetch = in_fetch;
        if ((ph == P_FETCH || ph == P_MEMRD || ph == P_MEMWR) && !rdy) stall_m = stall_m + 1'b1;
        if (last) ret_m = ret_m + 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_instr(input logic [5:0] op, input int wf, input int wm, input int exp_len);
        logic r;
        next_exp = exp_len;
        for (int k = 0; k <= wf; k++) cycle(P_FETCH, op, k == wf, 1'b0);
        r = 1'($urandom_range(0, 1));
        cycle(P_DECODE, op, r, 1'b0);
        r = 1'($urandom_range(0, 1));
        case (classify(op))
            C_LW: begin
                cycle(P_MEMADR, op, r, 1'b0);
                for (int k = 0; k <= wm; k++) cycle(P_MEMRD, op, k == wm, 1'b0);
                cycle(P_MEMWB, op, 1'($urandom_range(0, 1)), 1'b1);
            end
            C_SW: begin
                cycle(P_MEMADR, op, r, 1'b0);
                for (int k = 0; k <= wm; k++) cycle(P_MEMWR, op, k == wm, k == wm);
            end
            C_R: begin
                cycle(P_RTEX, op, r, 1'b0);
                cycle(P_RTWB, op, 1'($urandom_range(0, 1)), 1'b1);
            end
            C_IMM: begin
                cycle(P_IMMEX, op, r, 1'b0);
                cycle(P_IMMWB, op, 1'($urandom_range(0, 1)), 1'b1);
            end
            C_BR:  cycle(P_BRANCH, op, r, 1'b1);
            C_J:   cycle(P_JUMP, op, r, 1'b1);
            C_JAL: cycle(P_JAL, op, r, 1'b1);
            default: cycle(P_TRAP, op, r, 1'b1);
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        logic [5:0] legal_ops[11];
        logic [5:0] op;

        tbl.push_back('{6'b100011, 0, 0, 5});
        tbl.push_back('{6'b101011, 0, 0, 4});
        tbl.push_back('{6'b000000, 0, 0, 4});
        tbl.push_back('{6'b001000, 0, 0, 4});
        tbl.push_back('{6'b001100, 0, 0, 4});
        tbl.push_back('{6'b001101, 0, 0, 4});
        tbl.push_back('{6'b001010, 0, 0, 4});
        tbl.push_back('{6'b000100, 0, 0, 3});
        tbl.push_back('{6'b000101, 0, 0, 3});
        tbl.push_back('{6'b000010, 0, 0, 3});
        tbl.push_back('{6'b000011, 0, 0, 3});
        tbl.push_back('{6'b111111, 0, 0, 3});
        tbl.push_back('{6'b101011, 0, 3, 7});
        tbl.push_back('{6'b100011, 2, 1, 8});
        tbl.push_back('{6'b000000, 1, 0, 5});

        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
                      6'b001100, 6'b001101, 6'b001010, 6'b000010, 6'b000011};

        rst = 1'b1;
        opcode = 6'b000000;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (dut_o !== exp_out(P_FETCH, 6'b000000, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=%h", dut_o, exp_out(P_FETCH, 6'b000000, 1'b0));
        end
        check_counters("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) do_instr(tbl[i].op, tbl[i].wf, tbl[i].wm, tbl[i].cycles);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else op = legal_ops[$urandom_range(0, 10)];
            do_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
        end
        do_instr(6'b000010, 0, 0, 3);

        // Reset while a store is waiting on memory.
        next_exp = 0;
        cycle(P_FETCH, 6'b101011, 1'b1, 1'b0);
        cycle(P_DECODE, 6'b101011, 1'b0, 1'b0);
        cycle(P_MEMADR, 6'b101011, 1'b0, 1'b0);
        cycle(P_MEMWR, 6'b101011, 1'b0, 1'b0);
        cycle(P_MEMWR, 6'b101011, 1'b0, 1'b0);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        ret_m = '0;
        stall_m = '0;
        n_tests++;
        if (dut_o !== exp_out(P_FETCH, 6'b101011, 1'b0)) begin
            n_fail++;
            $display("FAIL rst_in_memwr got=%h exp=%h", dut_o, exp_out(P_FETCH, 6'b101011, 1'b0));
        end
        check_counters("rst_in_memwr");
        @(negedge clk);
        #1;
        n_tests++;
        if (mem_write !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hold mem_write=%0d mem_req=%0d exp 0/1", mem_write, mem_req);
        end
        @(negedge clk);
        rst = 1'b0;
        prev_in_fetch = 1'b0;
        pending = 0;
        do_instr(6'b100011, 0, 0, 5);
        do_instr(6'b000011, 0, 0, 3);
        do_instr(6'b000000, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
